// File: rtl/aes_pkg.sv
// Shared AES tables and helpers: S-box, Rcon, GF(2^8) column mixing, round count
// and the controller state type.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic int nr_of(input int key_bits);
        return (key_bits == 256) ? 14 : 10;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Past the last expansion step the index is never consumed; return zero there.
    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        return (idx < 4'd10) ? RCON[idx] : 8'h00;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One AES encryption round, purely combinational: SubBytes, ShiftRows,
// optional MixColumns (skipped on the final round), AddRoundKey.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    logic [7:0]   sb [16];
    logic [127:0] sr_flat;
    logic [127:0] mc_flat;

    genvar gi;

    // Byte n sits at row n%4, column n/4; row r rotates left by r columns.
    for (gi = 0; gi < 16; gi++) begin : g_bytes
        assign sb[gi] = SBOX[state_i[127-8*gi -: 8]];
        assign sr_flat[127-8*gi -: 8] = sb[4*(((gi/4) + (gi%4)) % 4) + (gi%4)];
    end

    for (gi = 0; gi < 4; gi++) begin : g_cols
        assign mc_flat[127-32*gi -: 32] = mix_column(sr_flat[127-32*gi -: 32]);
    end

    assign state_o = (last_i ? sr_flat : mc_flat) ^ rkey_i;

endmodule

// File: rtl/aes_iter_encryptor.sv
// Iterative AES-128/256 encryptor: one round per clock on a shared datapath,
// round keys expanded on the fly from a sliding key window.
module aes_iter_encryptor
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        data_in,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        data_out,
    output logic                busy
);

    localparam logic [3:0] NR = 4'(nr_of(KEY_BITS));

    aes_state_e          fsm_q;
    logic [3:0]          rcnt_q;
    logic [3:0]          rcon_idx_q;
    logic [127:0]        state_q;
    logic [KEY_BITS-1:0] key_q;
    logic                out_valid_q;

    logic [127:0]        state_d;
    logic [KEY_BITS-1:0] key_d;
    logic [127:0]        round_key;
    logic [127:0]        new_grp;
    logic [127:0]        base_w;
    logic [31:0]         temp_w;
    logic                rot_step;
    logic                last_round;

    // The oldest four window words plus the newest word yield the next group.
    assign base_w     = key_q[KEY_BITS-1 -: 128];
    assign last_round = (rcnt_q == NR);

    always_comb begin
        temp_w = rot_step
               ? (sub_word({key_q[23:0], key_q[31:24]}) ^ {rcon_of(rcon_idx_q), 24'h000000})
               : sub_word(key_q[31:0]);
        new_grp[127:96] = base_w[127:96] ^ temp_w;
        new_grp[95:64]  = base_w[95:64]  ^ new_grp[127:96];
        new_grp[63:32]  = base_w[63:32]  ^ new_grp[95:64];
        new_grp[31:0]   = base_w[31:0]   ^ new_grp[63:32];
    end

    if (KEY_BITS == 128) begin : g_k128
        assign rot_step  = 1'b1;
        assign round_key = new_grp;
        assign key_d     = new_grp;
    end else if (KEY_BITS == 256) begin : g_k256
        logic first_round;
        // Round 1 uses w4..w7 straight from the loaded key; no expansion yet.
        assign first_round = (rcnt_q == 4'd1);
        assign rot_step    = ~rcnt_q[0];
        assign round_key   = first_round ? key_q[127:0] : new_grp;
        assign key_d       = first_round ? key_q : {key_q[127:0], new_grp};
    end else begin : g_bad_key_bits
        $error("aes_iter_encryptor: KEY_BITS must be 128 or 256");
    end

    aes_round_comb u_round (
        .state_i (state_q),
        .rkey_i  (round_key),
        .last_i  (last_round),
        .state_o (state_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            rcnt_q      <= 4'd0;
            rcon_idx_q  <= 4'd0;
            state_q     <= '0;
            key_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= data_in ^ key_in[KEY_BITS-1 -: 128];
                        key_q      <= key_in;
                        rcnt_q     <= 4'd1;
                        rcon_idx_q <= 4'd0;
                        fsm_q      <= RUN;
                    end
                end
                RUN: begin
                    state_q <= state_d;
                    key_q   <= key_d;
                    if (rot_step) begin
                        rcon_idx_q <= rcon_idx_q + 4'd1;
                    end
                    if (last_round) begin
                        fsm_q       <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        rcnt_q <= rcnt_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_q       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q != IDLE);
    assign out_valid = out_valid_q;
    assign data_out  = state_q;

endmodule
